encode_mac_acc_sat_32s_16s: RTL and testbench
=============================================

Name: encode_mac_acc_sat_32s_16s

Overview:
- Downstream consumer of the 4-stage 16s×16s→32s multiplier in the ADPCM encode datapath.
- Accumulates a group of up to NTAPS signed 32-bit products into one predictor sum, for example the 6-tap zero predictor.
- Arithmetic-shifts the sum right by SHIFT, saturates it to 16 bits, and presents it on a valid/ready output.
- Upstream `ce` and `in_ready` together stall the multiplier pipeline when the output is back-pressured.

Parameters:
- PROD_WIDTH, 32, width of incoming signed product.
- ACC_WIDTH, 40, internal accumulator width; must be ≥ PROD_WIDTH + ceil(log2(NTAPS)).
- OUT_WIDTH, 16, width of saturated signed result.
- NTAPS, 6, maximum products per group; forced group end when reached.
- SHIFT, 14, arithmetic right-shift applied to the final sum.
- ROUND, 0, if 1 add 2^(SHIFT-1) before shifting; if 0 truncate toward −∞.

Ports:
- clk, in, 1, clock, rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- ce, in, 1, clock enable shared with the multiplier; ce=0 freezes all registers.
- in_data, in, PROD_WIDTH, signed product from the multiplier output.
- in_valid, in, 1, in_data valid (already aligned to the 4-cycle multiplier latency by the caller).
- in_last, in, 1, marks the final product of a group.
- in_ready, out, 1, block can accept a product; equals (state != HOLD).
- out_data, out, OUT_WIDTH, saturated shifted sum.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts.
- out_sat, out, 1, saturation occurred for this result.
- out_len, out, 3, number of products in this group (1..NTAPS).

Behaviour:
- Reset values: all outputs 0 except `in_ready`=1; state=IDLE, acc=0, count=0.
  - Reset mid-group discards the partial sum; no output is produced for that group.
- `ce`=0: no register changes; `out_valid` and `out_data` hold; no handshake completes on either side.
- Accept condition: `ce` & `in_valid` & `in_ready`. When `in_ready`=0, `in_valid` is ignored and the product is not consumed.
- States:
  - IDLE: on accept, acc ← sext(in_data), count ← 1.
    - If `in_last` or NTAPS==1: finalize, go to HOLD.
    - Otherwise go to ACC.
  - ACC: on accept, sum = acc + sext(in_data), count ← count+1.
    - If `in_last` or count==NTAPS−1 (before increment): finalize, go to HOLD.
    - Otherwise acc ← sum.
  - HOLD: `out_valid`=1. On `ce` & `out_ready`: `out_valid` ← 0, go to IDLE.
    - Next accept is possible the following cycle; no same-cycle bypass.
- Finalize, evaluated in the same edge as the last accept, on combinational sum s:
  - t = (s + (ROUND ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic.
  - If t > 2^(OUT_WIDTH-1)−1: `out_data`=32767, `out_sat`=1.
  - If t < −2^(OUT_WIDTH-1): `out_data`=−32768, `out_sat`=1.
  - Otherwise `out_data`=t[OUT_WIDTH-1:0], `out_sat`=0.
  - `out_len` ← count after this accept.
- Latency: `out_valid` rises on the first edge after the final accepted product, i.e. 1 cycle. Throughput is one product per cycle within a group.
- Forced end: reaching NTAPS without `in_last` ends the group normally. The next product starts a new group.
- `in_last` arriving with the first product gives a 1-product group, `out_len`=1.
- `out_data`, `out_sat` and `out_len` are stable for as long as `out_valid`=1.

Decomposition:
- Package encode_acc_pkg holds:
  - width constants: PROD_WIDTH, ACC_WIDTH, OUT_WIDTH;
  - NTAPS and SHIFT defaults;
  - state enum {IDLE, ACC, HOLD};
  - OUT_MAX and OUT_MIN constants.
- One combinational sub-module, encode_shift_sat: ACC_WIDTH in → OUT_WIDTH out plus a sat flag, parameterised by SHIFT and ROUND. It is reusable by other predictor stages.

Test Plan:
- 6× in_data=0x0000_4000 with `in_last` on the 6th → one cycle later `out_data`=6, `out_sat`=0, `out_len`=6.
- Single in_data=−16385 (0xFFFF_BFFF) with `in_last`, ROUND=0 → `out_data`=−2, `out_len`=1. With ROUND=1 → −1.
- 6× 0x3FFF_0001 → `out_data`=32767, `out_sat`=1. Then 6× 0xC000_0000 → `out_data`=−32768, `out_sat`=1.
- 8 products without `in_last`, each 0x0000_4000 → first result `out_len`=6, `out_data`=6. Second group closes at the 8th beat only if `in_last` is set there; otherwise it waits for more products.
- Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, `out_data` stable, no product consumed. Raise `out_ready` → transfer, and the next product is accepted the following cycle.
- Drive `ce`=0 for 3 cycles mid-group, then assert `reset` after 3 products of another group → result equals the no-stall result. After reset: `out_valid`=0, and the next group starts from acc=0.

Source files
------------

// File: rtl/encode_acc_pkg.sv
// Shared definitions for the ADPCM encode predictor accumulator.
// Holds default widths, tap count, shift amount, output saturation
// limits and the accumulator state encoding.
package encode_acc_pkg;

    localparam int PROD_WIDTH = 32;
    localparam int ACC_WIDTH  = 40;
    localparam int OUT_WIDTH  = 16;
    localparam int NTAPS      = 6;
    localparam int SHIFT      = 14;
    localparam int ROUND      = 0;
    localparam int LEN_WIDTH  = 3;

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = 16'sh7FFF;
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/encode_shift_sat.sv
// Combinational arithmetic right shift with optional round-half-up,
// followed by signed saturation to OUT_WIDTH bits.
// Ports:
//   din  - signed accumulator value (ACC_WIDTH)
//   dout - shifted, saturated result (OUT_WIDTH)
//   sat  - 1 when dout was clamped to the positive or negative limit
module encode_shift_sat #(
    parameter int ACC_WIDTH = encode_acc_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = encode_acc_pkg::OUT_WIDTH,
    parameter int SHIFT     = encode_acc_pkg::SHIFT,
    parameter int ROUND     = encode_acc_pkg::ROUND
) (
    input  logic signed [ACC_WIDTH-1:0] din,
    output logic        [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    // One guard bit so the rounding bias can never wrap the sum.
    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [EW-1:0] RND_BIAS =
        (ROUND != 0 && SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
    localparam logic signed [EW-1:0] LIM_HI = (EW'(1) << (OUT_WIDTH - 1)) - EW'(1);
    localparam logic signed [EW-1:0] LIM_LO = ~LIM_HI;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] shifted;

    always_comb begin
        ext     = {din[ACC_WIDTH-1], din};
        biased  = ext + RND_BIAS;
        shifted = biased >>> SHIFT;
        dout    = shifted[OUT_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > LIM_HI) begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat  = 1'b1;
        end else if (shifted < LIM_LO) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/encode_mac_acc_sat_32s_16s.sv
// Predictor-sum accumulator fed by the 4-stage 16s x 16s multiplier.
// Sums up to NTAPS signed products per group, then shifts and
// saturates the total and presents it on a valid/ready output.
// Ports:
//   clk, reset (async, active-high), ce (shared clock enable)
//   in_data/in_valid/in_last/in_ready - product input handshake
//   out_data/out_valid/out_ready      - result output handshake
//   out_sat - result was clamped; out_len - products in the group
module encode_mac_acc_sat_32s_16s #(
    parameter int PROD_WIDTH = encode_acc_pkg::PROD_WIDTH,
    parameter int ACC_WIDTH  = encode_acc_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = encode_acc_pkg::OUT_WIDTH,
    parameter int NTAPS      = encode_acc_pkg::NTAPS,
    parameter int SHIFT      = encode_acc_pkg::SHIFT,
    parameter int ROUND      = encode_acc_pkg::ROUND
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat,
    output logic [2:0]            out_len
);

    import encode_acc_pkg::*;

    acc_state_e state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [2:0]                  count, count_nxt, count_inc;
    logic [OUT_WIDTH-1:0]        sat_data, out_data_nxt;
    logic                        sat_flag, out_sat_nxt;
    logic [2:0]                  out_len_nxt;
    logic                        accept;
    logic                        last_beat;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};

    encode_shift_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .ROUND     (ROUND)
    ) u_shift_sat (
        .din  (sum),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        count_nxt    = count;
        out_data_nxt = out_data;
        out_sat_nxt  = out_sat;
        out_len_nxt  = out_len;

        accept    = ce & in_valid & in_ready;
        // count is 0 whenever the state is IDLE, so the first product
        // of a group and later ones share the same accept path.
        base      = (state == ACC) ? acc : '0;
        sum       = base + prod_ext;
        count_inc = count + 3'd1;
        last_beat = in_last | (count == 3'(NTAPS - 1));

        unique case (state)
            IDLE, ACC: begin
                if (accept) begin
                    if (last_beat) begin
                        out_data_nxt = sat_data;
                        out_sat_nxt  = sat_flag;
                        out_len_nxt  = count_inc;
                        acc_nxt      = '0;
                        count_nxt    = '0;
                        state_nxt    = HOLD;
                    end else begin
                        acc_nxt   = sum;
                        count_nxt = count_inc;
                        state_nxt = ACC;
                    end
                end
            end
            HOLD: begin
                if (ce && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_len  <= '0;
        end else if (ce) begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            count    <= count_nxt;
            out_data <= out_data_nxt;
            out_sat  <= out_sat_nxt;
            out_len  <= out_len_nxt;
        end
    end

endmodule

// File: tb/tb_encode_mac_acc_sat_32s_16s.sv
module tb_encode_mac_acc_sat_32s_16s;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic [2:0]  l;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;
    logic [2:0]  out_len;

    logic        r_valid;
    logic        r_in_ready;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic        r_ready;
    logic        r_out_sat;
    logic [2:0]  r_out_len;

    int checks;
    int failures;
    exp_t sb[$];

    encode_mac_acc_sat_32s_16s dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .out_len   (out_len)
    );

    encode_mac_acc_sat_32s_16s #(.ROUND(1)) dut_rnd (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_data   (in_data),
        .in_valid  (r_valid),
        .in_last   (in_last),
        .in_ready  (r_in_ready),
        .out_data  (r_out_data),
        .out_valid (r_out_valid),
        .out_ready (r_ready),
        .out_sat   (r_out_sat),
        .out_len   (r_out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input longint s, input int len, input bit rnd);
        exp_t   e;
        longint t;
        t = (s + (rnd ? 64'sd8192 : 64'sd0)) >>> 14;
        if (t > 64'sd32767) begin
            e.d = 16'h7FFF;
            e.s = 1'b1;
        end else if (t < -64'sd32768) begin
            e.d = 16'h8000;
            e.s = 1'b1;
        end else begin
            e.d = t[15:0];
            e.s = 1'b0;
        end
        e.l = 3'(len);
        return e;
    endfunction

    function automatic longint sx(input logic [31:0] d);
        return longint'($signed(d));
    endfunction

    // Output monitor: pops the scoreboard on every completed output handshake.
    always @(negedge clk) begin
        if (!reset && ce && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got data=%h len=%0d required none", out_data, out_len);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d) begin
                    failures++;
                    $display("FAIL sb_data got %h required %h", out_data, e.d);
                end
                checks++;
                if (out_sat !== e.s) begin
                    failures++;
                    $display("FAIL sb_sat got %0b required %0b", out_sat, e.s);
                end
                checks++;
                if (out_len !== e.l) begin
                    failures++;
                    $display("FAIL sb_len got %0d required %0d", out_len, e.l);
                end
            end
        end
    end

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!(in_ready && ce)) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 || out_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout pending=%0d required 0", sb.size());
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %0b required 1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rst_out_data got %h required 0000", out_data); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_out_sat got %0b required 0", out_sat); end
        checks++; if (out_len !== 3'd0) begin failures++; $display("FAIL rst_out_len got %0d required 0", out_len); end
    endtask

    task automatic test_basic();
        sb.push_back('{d: 16'd6, s: 1'b0, l: 3'd6});
        for (int i = 0; i < 6; i++) drive_beat(32'h0000_4000, (i == 5));
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid got %0b required 1", out_valid); end
        checks++; if (out_data !== 16'd6) begin failures++; $display("FAIL basic_data got %h required 0006", out_data); end
        checks++; if (out_len !== 3'd6) begin failures++; $display("FAIL basic_len got %0d required 6", out_len); end
        wait_drain();
    endtask

    task automatic test_single_round();
        sb.push_back('{d: 16'hFFFE, s: 1'b0, l: 3'd1});
        r_valid = 1'b1;
        drive_beat(32'hFFFF_BFFF, 1'b1);
        r_valid = 1'b0;
        checks++; if (out_data !== 16'hFFFE) begin failures++; $display("FAIL single_trunc got %h required fffe", out_data); end
        checks++; if (r_out_valid !== 1'b1) begin failures++; $display("FAIL single_rnd_valid got %0b required 1", r_out_valid); end
        checks++; if (r_out_data !== 16'hFFFF) begin failures++; $display("FAIL single_rnd_data got %h required ffff", r_out_data); end
        checks++; if (r_out_len !== 3'd1) begin failures++; $display("FAIL single_rnd_len got %0d required 1", r_out_len); end
        checks++; if (r_out_sat !== 1'b0) begin failures++; $display("FAIL single_rnd_sat got %0b required 0", r_out_sat); end
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL single_rnd_drain got %0b required 0", r_out_valid); end
        wait_drain();
    endtask

    task automatic test_saturation();
        sb.push_back('{d: 16'h7FFF, s: 1'b1, l: 3'd6});
        for (int i = 0; i < 6; i++) drive_beat(32'h3FFF_0001, (i == 5));
        sb.push_back('{d: 16'h8000, s: 1'b1, l: 3'd6});
        for (int i = 0; i < 6; i++) drive_beat(32'hC000_0000, (i == 5));
        checks++; if (out_sat !== 1'b1) begin failures++; $display("FAIL sat_neg_flag got %0b required 1", out_sat); end
        wait_drain();
    endtask

    task automatic test_forced_end();
        sb.push_back('{d: 16'd6, s: 1'b0, l: 3'd6});
        for (int i = 0; i < 6; i++) drive_beat(32'h0000_4000, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL forced_valid got %0b required 1", out_valid); end
        drive_beat(32'h0000_4000, 1'b0);
        drive_beat(32'h0000_4000, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL forced_wait got %0b required 0", out_valid); end
        end
        sb.push_back('{d: 16'd3, s: 1'b0, l: 3'd3});
        drive_beat(32'h0000_4000, 1'b1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        exp_t e;
        a = 32'h0123_4567;
        b = 32'hFF00_1234;
        e = model(sx(a) + sx(b), 2, 1'b0);
        sb.push_back(e);
        out_ready = 1'b0;
        drive_beat(a, 1'b0);
        drive_beat(b, 1'b1);
        sb.push_back('{d: 16'd1, s: 1'b0, l: 3'd1});
        in_data  = 32'h0000_4000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %0b required 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got %0b required 1", out_valid); end
            checks++; if (out_data !== e.d) begin failures++; $display("FAIL bp_stable got %h required %h", out_data, e.d); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_xfer got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got %0b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got %0b required 1", out_valid); end
        checks++; if (out_len !== 3'd1) begin failures++; $display("FAIL bp_next_len got %0d required 1", out_len); end
        wait_drain();
    endtask

    task automatic test_ce_stall_reset();
        logic [31:0] p [6];
        longint s;
        exp_t e;
        s = 0;
        for (int i = 0; i < 6; i++) begin
            p[i] = {{8{1'b0}}, 24'($urandom())} ^ ((i % 2) ? 32'hFFF0_0000 : 32'h0);
            s += sx(p[i]);
        end
        e = model(s, 6, 1'b0);
        sb.push_back(e);
        for (int i = 0; i < 3; i++) drive_beat(p[i], 1'b0);
        ce = 1'b0;
        in_data  = p[3];
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ce_mid_valid got %0b required 0", out_valid); end
        end
        ce = 1'b1;
        drive_beat(p[3], 1'b0);
        drive_beat(p[4], 1'b0);
        out_ready = 1'b0;
        drive_beat(p[5], 1'b1);
        ce = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ce_hold_valid got %0b required 1", out_valid); end
            checks++; if (out_data !== e.d) begin failures++; $display("FAIL ce_hold_data got %h required %h", out_data, e.d); end
        end
        ce = 1'b1;
        wait_drain();

        for (int i = 0; i < 3; i++) drive_beat(32'h7FFF_0000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %0b required 1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL mid_rst_data got %h required 0000", out_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        sb.push_back('{d: 16'd1, s: 1'b0, l: 3'd1});
        drive_beat(32'h0000_4000, 1'b1);
        checks++; if (out_data !== 16'd1) begin failures++; $display("FAIL post_rst_data got %h required 0001", out_data); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 8; g++) begin
            int len;
            longint s;
            logic lst;
            logic [31:0] d;
            len = $urandom_range(1, 6);
            s = 0;
            for (int i = 0; i < len; i++) begin
                d = $urandom();
                if (g % 2) d = {{12{d[19]}}, d[19:0]};
                s += sx(d);
                lst = (i == len - 1) && ((len < 6) || ($urandom_range(0, 1) == 1));
                if (i == len - 1) sb.push_back(model(s, len, 1'b0));
                drive_beat(d, lst);
            end
        end
        wait_drain();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        ce        = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        r_valid   = 1'b0;
        r_ready   = 1'b0;

        test_reset();
        test_basic();
        test_single_round();
        test_saturation();
        test_forced_end();
        test_backpressure();
        test_ce_stall_reset();
        test_back_to_back();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
